mem_stage_ext: RTL and testbench

MEM_STAGE_EXT -- requirements
Module: mem_stage_ext

---
 rtl/riscv_mem_pkg.sv | 33 +++
 rtl/data_mem_be.sv | 26 ++
 rtl/mem_stage_ext.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_ext.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared load/store size encodings and memory-stage FSM states.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // Reserved encodings (011, 110, 111) behave as full-word accesses.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_be.sv
// Word-organised data RAM with per-byte write enables, async read, sync write.
module data_mem_be #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage_ext.sv
// Pipeline memory stage: sized loads/stores, misalign detection, optional
// multi-cycle access latency and the MEM/WB pipeline register.
module mem_stage_ext
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned MEM_LAT     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemtoRegM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [4:0]      WriteRegM,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            FlushW,
  output logic            StallM,
  output logic            MisalignM,
  output logic            RegWriteW,
  output logic            MemtoRegW,
  output logic            MisalignW,
  output logic [4:0]      WriteRegW,
  output logic [XLEN-1:0] ALUOutW,
  output logic [XLEN-1:0] ReadDataW
);

  localparam int unsigned      AW     = $clog2(DEPTH_WORDS);
  localparam bit               LAT_EN = (MEM_LAT != 0);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LAT);

  mem_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_access, w_unsigned, w_commit, w_we;
  acc_size_e        w_size;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_rdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_ldata;

  assign w_off      = ALUOutM[1:0];
  assign w_access   = MemReadM | MemWriteM;
  assign w_size     = f3_size(Funct3M);
  assign w_unsigned = Funct3M[2] & (w_size != SZ_W);

  always_comb begin : misalign_detect
    MisalignM = 1'b0;
    if (w_access) begin
      case (w_size)
        SZ_H:    MisalignM = w_off[0];
        SZ_W:    MisalignM = |w_off;
        default: MisalignM = 1'b0;
      endcase
    end
  end

  // Replicate store data across lanes; byte enables pick the target lane.
  always_comb begin : store_lanes
    w_be    = 4'b1111;
    w_wdata = WriteDataM[31:0];
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin : load_extract
    w_byte  = w_rdata[{w_off, 3'b000} +: 8];
    w_half  = w_rdata[{w_off[1], 4'b0000} +: 16];
    w_ldata = w_rdata;
    case (w_size)
      SZ_B: w_ldata = w_unsigned ? {{(XLEN-8){1'b0}}, w_byte}
                                 : {{(XLEN-8){w_byte[7]}}, w_byte};
      SZ_H: w_ldata = w_unsigned ? {{(XLEN-16){1'b0}}, w_half}
                                 : {{(XLEN-16){w_half[15]}}, w_half};
      default: ;
    endcase
    if (MisalignM) w_ldata = '0;
  end

  always_ff @(posedge clk) begin : fsm_state
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // w_commit marks the edge at which the access completes and may write.
  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    StallM      = 1'b0;
    w_commit    = 1'b0;
    if (!LAT_EN) begin
      w_commit = w_access;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access && !MisalignM) begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = LAT_LD;
            StallM      = 1'b1;
          end
        end
        ST_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_commit    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            StallM    = 1'b1;
          end
        end
      endcase
    end
  end

  assign w_we = w_commit & MemWriteM & ~MisalignM & ~rst;

  data_mem_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem (
    .clk    (clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_addr (ALUOutM[AW+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  // MEM/WB register: reset, flush and stall all load a bubble.
  always_ff @(posedge clk) begin : memwb_reg
    if (rst || FlushW || StallM) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      MisalignW <= 1'b0;
      WriteRegW <= '0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
    end else begin
      RegWriteW <= RegWriteM & ~MisalignM;
      MemtoRegW <= MemtoRegM;
      MisalignW <= MisalignM;
      WriteRegW <= WriteRegM;
      ALUOutW   <= ALUOutM;
      ReadDataW <= w_ldata;
    end
  end

endmodule

// File: tb/tb_mem_stage_ext.sv
// Scoreboarded random + directed bench for mem_stage_ext at latencies 0, 2 and 3.
module tb_mem_stage_ext;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [NI];
  logic        reg_write_m, mem_to_reg_m, mem_read_m, mem_write_m, flush_w;
  logic [2:0]  funct3_m;
  logic [4:0]  write_reg_m;
  logic [31:0] alu_out_m, write_data_m;

  logic        stall_v [NI];
  logic        mis_v   [NI];
  logic        rw_v    [NI];
  logic        m2r_v   [NI];
  logic        misw_v  [NI];
  logic [4:0]  wr_v    [NI];
  logic [31:0] alu_v   [NI];
  logic [31:0] rd_v    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_stage_ext #(
      .XLEN(32), .DEPTH_WORDS(64), .MEM_LAT((g == 0) ? 0 : g + 1)
    ) u_dut (
      .clk(clk), .rst(rst_v[g]),
      .RegWriteM(reg_write_m), .MemtoRegM(mem_to_reg_m),
      .MemReadM(mem_read_m), .MemWriteM(mem_write_m),
      .Funct3M(funct3_m), .WriteRegM(write_reg_m),
      .ALUOutM(alu_out_m), .WriteDataM(write_data_m), .FlushW(flush_w),
      .StallM(stall_v[g]), .MisalignM(mis_v[g]),
      .RegWriteW(rw_v[g]), .MemtoRegW(m2r_v[g]), .MisalignW(misw_v[g]),
      .WriteRegW(wr_v[g]), .ALUOutW(alu_v[g]), .ReadDataW(rd_v[g])
    );
  end

  typedef struct {
    logic        flush;
    logic        rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        misalign;
    logic [4:0]  write_reg;
    logic [31:0] alu;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [31:0] ref_mem [NI][64];
  int          n_chk = 0, n_fail = 0;
  int          cur = 0;
  bit          mon_en = 1'b0, prev_cap = 1'b0, prev_stall = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat inst %0d) @%0t: got %h expected %h", name, cur, $time, act, exp);
    end
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic int ref_size(logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Byte-array view of memory: little-endian, word index wraps at 64.
  function automatic logic [31:0] ref_load(int k, logic [2:0] f3, logic [31:0] a);
    int sz, off, w;
    logic [31:0] word, v;
    sz  = ref_size(f3);
    off = int'(a % 4);
    w   = int'((a / 4) % 64);
    if (off + sz > 4) return 32'h0;
    word = ref_mem[k][w];
    v    = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (sz < 4 && !(f3 == 3'b100 || f3 == 3'b101) && v[8*sz-1])
      v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  function automatic void ref_store(int k, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    int sz, off, w;
    sz  = ref_size(f3);
    off = int'(a % 4);
    w   = int'((a / 4) % 64);
    for (int i = 0; i < sz; i++) ref_mem[k][w][8*(off+i) +: 8] = d[8*i +: 8];
  endfunction

  // Monitor: after every non-stalled edge pop one expectation; after a stalled edge expect a bubble.
  always @(negedge clk) begin
    if (mon_en && prev_cap) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL capture_queue (lat inst %0d) @%0t: got capture expected none", cur, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("RegWriteW", 32'(rw_v[cur]), 32'(mon_e.reg_write));
        chk("MisalignW", 32'(misw_v[cur]), 32'(mon_e.misalign));
        if (!mon_e.flush) begin
          chk("MemtoRegW", 32'(m2r_v[cur]), 32'(mon_e.mem_to_reg));
          chk("WriteRegW", 32'(wr_v[cur]), 32'(mon_e.write_reg));
          chk("ALUOutW", alu_v[cur], mon_e.alu);
          if (mon_e.rd) chk("ReadDataW", rd_v[cur], mon_e.rdata);
        end
      end
    end else if (mon_en && prev_stall) begin
      chk("stall_bubble_RegWriteW", 32'(rw_v[cur]), 32'h0);
      chk("stall_bubble_MisalignW", 32'(misw_v[cur]), 32'h0);
    end
    prev_cap   = mon_en && (stall_v[cur] === 1'b0) && !rst_v[cur];
    prev_stall = mon_en && (stall_v[cur] === 1'b1) && !rst_v[cur];
  end

  task automatic drive_nop();
    reg_write_m = 1'b0; mem_to_reg_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
    flush_w = 1'b0; funct3_m = 3'b010; write_reg_m = 5'd0;
    alu_out_m = 32'h0; write_data_m = 32'h0;
  endtask

  // Issue one instruction, queue its expected W record, update model, wait for completion.
  task automatic issue(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [2:0] f3, input logic [4:0] wreg, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic fl,
                       input bit use_ovr, input logic [31:0] ovr);
    exp_t e;
    bit   mis;
    int   stalls, exp_stalls;
    mem_read_m = rd; mem_write_m = wr; reg_write_m = rw; mem_to_reg_m = m2r;
    funct3_m = f3; write_reg_m = wreg; alu_out_m = addr; write_data_m = wdata; flush_w = fl;
    mis          = (rd || wr) && (addr % ref_size(f3) != 0);
    e.flush      = fl;
    e.rd         = rd;
    e.reg_write  = rw && !mis && !fl;
    e.mem_to_reg = m2r;
    e.misalign   = mis && !fl;
    e.write_reg  = wreg;
    e.alu        = addr;
    e.rdata      = mis ? 32'h0 : (use_ovr ? ovr : ref_load(cur, f3, addr));
    exp_q.push_back(e);
    if (wr && !mis) ref_store(cur, f3, addr, wdata);
    exp_stalls = ((rd || wr) && !mis) ? lat_of(cur) : 0;
    #1;
    chk("MisalignM", 32'(mis_v[cur]), 32'(mis));
    stalls = 0;
    @(negedge clk);
    while (stall_v[cur] === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(posedge clk); #1;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 1'b1, 1'b0, 1'b0, f3, 5'd0, a, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] ovr);
    issue(1'b1, 1'b0, 1'b1, 1'b1, f3, 5'd7, a, 32'h0, 1'b0, 1'b1, ovr);
  endtask

  task automatic rand_issue();
    logic [31:0] a;
    int kind;
    a = $urandom & 32'h0000_0FFF;
    if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
    kind = $urandom_range(0, 3);
    issue(kind == 1 || kind == 3, kind == 2, 1'($urandom), 1'($urandom),
          3'($urandom_range(0, 7)), 5'($urandom), a, $urandom,
          $urandom_range(0, 9) == 0, 1'b0, 32'h0);
  endtask

  // Finish with a nop so the FSM rests in IDLE, then stop the monitor.
  task automatic drain();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    mon_en = 1'b0;
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic check_w_zero(input string tag);
    chk({tag, "_RegWriteW"}, 32'(rw_v[cur]), 32'h0);
    chk({tag, "_MemtoRegW"}, 32'(m2r_v[cur]), 32'h0);
    chk({tag, "_MisalignW"}, 32'(misw_v[cur]), 32'h0);
    chk({tag, "_WriteRegW"}, 32'(wr_v[cur]), 32'h0);
    chk({tag, "_ALUOutW"}, alu_v[cur], 32'h0);
    chk({tag, "_ReadDataW"}, rd_v[cur], 32'h0);
    chk({tag, "_StallM"}, 32'(stall_v[cur]), 32'h0);
  endtask

  task automatic start_phase(input int k);
    cur = k;
    @(posedge clk); #1;
    rst_v[k] = 1'b1;
    reg_write_m = 1'b1; mem_to_reg_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0;
    flush_w = 1'b0; funct3_m = 3'b010; write_reg_m = 5'd9;
    alu_out_m = 32'h0000_0044; write_data_m = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    rst_v[k] = 1'b0;
    drive_nop();
    @(negedge clk);
    check_w_zero("reset");
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int w = 0; w < 64; w++) st(3'b010, 32'(w * 4) | (32'($urandom_range(0, 15)) << 8), $urandom);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) rst_v[k] = 1'b1;
    drive_nop();

    // Latency 0: lane extraction, sign handling, misalign, wrap, flush.
    start_phase(0);
    st(3'b010, 32'h10, 32'hDEAD_BEEF);
    ld(3'b000, 32'h13, 32'hFFFF_FFDE);
    ld(3'b100, 32'h13, 32'h0000_00DE);
    ld(3'b111, 32'h10, 32'hDEAD_BEEF);
    st(3'b010, 32'h20, 32'h0);
    st(3'b001, 32'h22, 32'h0000_8001);
    ld(3'b010, 32'h20, 32'h8001_0000);
    ld(3'b001, 32'h22, 32'hFFFF_8001);
    ld(3'b101, 32'h22, 32'h0000_8001);
    st(3'b010, 32'h04, 32'h0102_0304);
    ld(3'b010, 32'h06, 32'h0);
    st(3'b010, 32'h06, 32'hAAAA_AAAA);
    ld(3'b010, 32'h04, 32'h0102_0304);
    st(3'b010, 32'h110, 32'hCAFE_F00D);
    ld(3'b010, 32'h010, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 5'd3, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
    repeat (120) rand_issue();
    drain();
    rst_v[0] = 1'b1;

    // Latency 2: store then load of the same word.
    start_phase(1);
    st(3'b010, 32'h80, 32'h5A5A_A5A5);
    ld(3'b010, 32'h80, 32'h5A5A_A5A5);
    ld(3'b001, 32'h83, 32'h0);
    repeat (120) rand_issue();
    drain();
    rst_v[1] = 1'b1;

    // Latency 3: reset in the second BUSY cycle aborts the store.
    start_phase(2);
    st(3'b010, 32'h40, 32'h1111_1111);
    repeat (120) rand_issue();
    st(3'b010, 32'h40, 32'h1111_1111);
    drain();
    @(posedge clk); #1;
    mem_write_m = 1'b1; funct3_m = 3'b010; alu_out_m = 32'h40; write_data_m = 32'h2222_2222;
    reg_write_m = 1'b1; write_reg_m = 5'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy2_StallM", 32'(stall_v[2]), 32'h1);
    rst_v[2] = 1'b1;
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    drive_nop();
    @(negedge clk);
    check_w_zero("abort");
    @(posedge clk); #1;
    mon_en = 1'b1;
    ld(3'b010, 32'h40, 32'h1111_1111);
    drain();
    rst_v[2] = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
